// File: rtl/localbus_pkg.sv
// Shared types and constants for the local-bus initiator.
package localbus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALE,
      ST_SETUP,
      ST_WAIT_ACK,
      ST_RELEASE,
      ST_RESP
   } lb_state_t;

   localparam logic LB_RD = 1'b1;
   localparam logic LB_WR = 1'b0;

   localparam int LB_CNT_W = 16;

endpackage

// File: rtl/localbus_master.sv
// Local-bus initiator: turns a valid/ready command into a multiplexed
// address/data bus cycle and reports read data or a timeout.
module localbus_master
   import localbus_pkg::*;
#(
   parameter int unsigned ALE_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_rd,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_timeout,
   output logic        localbus_cs_n,
   output logic        localbus_rd_wr,
   output logic [31:0] localbus_data,
   output logic        localbus_ale,
   input  logic        localbus_ack_n,
   input  logic [31:0] localbus_data_out
);

   localparam logic [LB_CNT_W-1:0] ALE_LAST = LB_CNT_W'(ALE_CYCLES - 1);
   localparam logic [LB_CNT_W-1:0] TMO_LAST = LB_CNT_W'(TIMEOUT - 1);

   lb_state_t           state_q, state_d;
   logic [LB_CNT_W-1:0] cnt_q, cnt_d;
   logic                rd_q, rd_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                tmo_q, tmo_d;
   logic                cs_n_q, cs_n_d;
   logic                ale_q, ale_d;
   logic                rd_wr_q, rd_wr_d;
   logic [31:0]         data_q, data_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [31:0]         rsp_rdata_q, rsp_rdata_d;
   logic                rsp_timeout_q, rsp_timeout_d;

   // Bus outputs are computed for the next state so they leave flops
   // aligned with the state register.
   always_comb begin
      state_d       = state_q;
      cnt_d         = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      rd_d          = rd_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      tmo_d         = tmo_q;
      cs_n_d        = cs_n_q;
      ale_d         = ale_q;
      rd_wr_d       = rd_wr_q;
      data_d        = data_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_timeout_d = rsp_timeout_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               rd_d    = cmd_rd;
               wdata_d = cmd_wdata;
               rdata_d = '0;
               tmo_d   = 1'b0;
               state_d = ST_ALE;
               cnt_d   = '0;
               ale_d   = 1'b1;
               cs_n_d  = 1'b1;
               data_d  = cmd_addr;
               rd_wr_d = cmd_rd;
            end
         end
         ST_ALE: begin
            if (cnt_q == ALE_LAST) begin
               state_d = ST_SETUP;
               cnt_d   = '0;
               ale_d   = 1'b0;
               data_d  = (rd_q == LB_WR) ? wdata_q : '0;
            end
         end
         ST_SETUP: begin
            state_d = ST_WAIT_ACK;
            cnt_d   = '0;
            cs_n_d  = 1'b0;
         end
         ST_WAIT_ACK: begin
            // An ack on the final counted cycle still beats the timeout.
            if (!localbus_ack_n || cnt_q == TMO_LAST) begin
               if (!localbus_ack_n) begin
                  rdata_d = (rd_q == LB_RD) ? localbus_data_out : '0;
               end else begin
                  tmo_d   = 1'b1;
                  rdata_d = '0;
               end
               state_d = ST_RELEASE;
               cnt_d   = '0;
               cs_n_d  = 1'b1;
               data_d  = '0;
               rd_wr_d = LB_RD;
            end
         end
         ST_RELEASE: begin
            if (localbus_ack_n || cnt_q == TMO_LAST) begin
               state_d       = ST_RESP;
               cnt_d         = '0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = rdata_q;
               rsp_timeout_d = tmo_q | ~localbus_ack_n;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         rd_q          <= LB_RD;
         wdata_q       <= '0;
         rdata_q       <= '0;
         tmo_q         <= 1'b0;
         cs_n_q        <= 1'b1;
         ale_q         <= 1'b0;
         rd_wr_q       <= LB_RD;
         data_q        <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rd_q          <= rd_d;
         wdata_q       <= wdata_d;
         rdata_q       <= rdata_d;
         tmo_q         <= tmo_d;
         cs_n_q        <= cs_n_d;
         ale_q         <= ale_d;
         rd_wr_q       <= rd_wr_d;
         data_q        <= data_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign cmd_ready      = (state_q == ST_IDLE);
   assign rsp_valid      = rsp_valid_q;
   assign rsp_rdata      = rsp_rdata_q;
   assign rsp_timeout    = rsp_timeout_q;
   assign localbus_cs_n  = cs_n_q;
   assign localbus_ale   = ale_q;
   assign localbus_rd_wr = rd_wr_q;
   assign localbus_data  = data_q;

endmodule
